// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN core: LIF FSM state encoding,
// default datapath widths and a saturating adder.
package snn_pkg;

  localparam int DEF_SUM_WIDTH = 16;
  localparam int DEF_V_WIDTH   = 16;
  localparam int DEF_ID_WIDTH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_EMIT = 2'd2
  } lif_state_e;

  // Unsigned add clamped to 2^width-1; operands are zero-extended to 32 bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] max_v;
    sum   = {1'b0, a} + {1'b0, b};
    max_v = (33'd1 << width) - 33'd1;
    return (sum > max_v) ? max_v[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/neuron_state_regs.sv
// Per-neuron {membrane, refractory count} storage: one combinational read
// port, one write port, synchronous clear-all with priority over the write.
module neuron_state_regs #(
  parameter int NUM_NEURONS = 16,
  parameter int V_WIDTH     = 16,
  parameter int REF_WIDTH   = 3,
  parameter int ID_WIDTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic [ID_WIDTH-1:0]  i_rd_id,
  output logic [V_WIDTH-1:0]   o_rd_v,
  output logic [REF_WIDTH-1:0] o_rd_ref,
  input  logic                 i_wr_en,
  input  logic [ID_WIDTH-1:0]  i_wr_id,
  input  logic [V_WIDTH-1:0]   i_wr_v,
  input  logic [REF_WIDTH-1:0] i_wr_ref
);

  logic [V_WIDTH-1:0]   r_v   [NUM_NEURONS];
  logic [REF_WIDTH-1:0] r_ref [NUM_NEURONS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_v[i]   <= '0;
        r_ref[i] <= '0;
      end
    end else if (i_clear) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_v[i]   <= '0;
        r_ref[i] <= '0;
      end
    end else if (i_wr_en) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (ID_WIDTH'(i) == i_wr_id) begin
          r_v[i]   <= i_wr_v;
          r_ref[i] <= i_wr_ref;
        end
      end
    end
  end

  // Decoded read so ids beyond NUM_NEURONS simply return zero.
  always_comb begin
    o_rd_v   = '0;
    o_rd_ref = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (ID_WIDTH'(i) == i_rd_id) begin
        o_rd_v   = r_v[i];
        o_rd_ref = r_ref[i];
      end
    end
  end

endmodule

// File: rtl/lif_neuron_unit.sv
// Leaky integrate-and-fire update for a bank of neurons, one MAC sum at a time.
// Define LIF_SOFT_RESET_EN to keep the above-threshold residual on fire.
module lif_neuron_unit
  import snn_pkg::*;
#(
  parameter int SUM_WIDTH    = DEF_SUM_WIDTH,
  parameter int V_WIDTH      = DEF_V_WIDTH,
  parameter int NUM_NEURONS  = 16,
  parameter int ID_WIDTH     = DEF_ID_WIDTH,
  parameter int LEAK_SHIFT   = 4,
  parameter int REFRAC_STEPS = 2,
  parameter int REF_WIDTH    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear_all,
  input  logic [V_WIDTH-1:0]   i_threshold,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [ID_WIDTH-1:0]  i_neuron_id,
  input  logic [SUM_WIDTH-1:0] i_sum,
  output logic                 o_spike_valid,
  input  logic                 i_spike_ready,
  output logic [ID_WIDTH-1:0]  o_spike_id,
  output logic                 o_busy
);

  // Handshakes: a transfer happens on the rising clk edge where valid and
  // ready are both high; valid never waits on ready, and a valid payload
  // stays stable until that edge. i_clear_all forces o_ready low.

  lif_state_e           r_state;
  lif_state_e           w_state_nxt;
  logic [ID_WIDTH-1:0]  r_id;
  logic [SUM_WIDTH-1:0] r_sum;
  logic [V_WIDTH-1:0]   r_thr;
  logic [ID_WIDTH-1:0]  r_spike_id;

  logic [V_WIDTH-1:0]   w_rd_v;
  logic [REF_WIDTH-1:0] w_rd_ref;
  logic                 w_wr_en;
  logic [V_WIDTH-1:0]   w_wr_v;
  logic [REF_WIDTH-1:0] w_wr_ref;
  logic                 w_fire;
  logic                 w_id_ok;
  logic                 w_accept;
  logic [V_WIDTH-1:0]   w_v_leak;
  logic [V_WIDTH-1:0]   w_v_int;
  logic [V_WIDTH-1:0]   w_v_fired;

  neuron_state_regs #(
    .NUM_NEURONS (NUM_NEURONS),
    .V_WIDTH     (V_WIDTH),
    .REF_WIDTH   (REF_WIDTH),
    .ID_WIDTH    (ID_WIDTH)
  ) u_state (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (i_clear_all),
    .i_rd_id  (r_id),
    .o_rd_v   (w_rd_v),
    .o_rd_ref (w_rd_ref),
    .i_wr_en  (w_wr_en),
    .i_wr_id  (r_id),
    .i_wr_v   (w_wr_v),
    .i_wr_ref (w_wr_ref)
  );

  assign o_ready       = (r_state == ST_IDLE) && !i_clear_all;
  assign o_spike_valid = (r_state == ST_EMIT);
  assign o_spike_id    = r_spike_id;
  assign o_busy        = (r_state != ST_IDLE);
  assign w_accept      = i_valid && o_ready;

  assign w_id_ok  = (int'(r_id) < NUM_NEURONS);
  assign w_v_leak = w_rd_v - (w_rd_v >> LEAK_SHIFT);
  assign w_v_int  = V_WIDTH'(sat_add(32'(w_v_leak), 32'(r_sum), V_WIDTH));

`ifdef LIF_SOFT_RESET_EN
  assign w_v_fired = w_v_int - r_thr;
`else
  assign w_v_fired = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_wr_v      = '0;
    w_wr_ref    = '0;
    w_fire      = 1'b0;
    if (i_clear_all) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (i_valid) w_state_nxt = ST_CALC;
        ST_CALC: begin
          if (w_id_ok) begin
            w_wr_en = 1'b1;
            if (w_rd_ref != '0) begin
              w_wr_v   = '0;
              w_wr_ref = w_rd_ref - REF_WIDTH'(1);
            end else if (w_v_int >= r_thr) begin
              w_fire   = 1'b1;
              w_wr_v   = w_v_fired;
              w_wr_ref = REF_WIDTH'(REFRAC_STEPS);
            end else begin
              w_wr_v   = w_v_int;
            end
          end
          w_state_nxt = w_fire ? ST_EMIT : ST_IDLE;
        end
        ST_EMIT: if (i_spike_ready) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_id       <= '0;
      r_sum      <= '0;
      r_thr      <= '0;
      r_spike_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_id  <= i_neuron_id;
        r_sum <= i_sum;
        r_thr <= i_threshold;
      end
      if (i_clear_all)  r_spike_id <= '0;
      else if (w_fire)  r_spike_id <= r_id;
    end
  end

endmodule

// File: tb/tb_lif_neuron_unit.sv
// Directed bench for lif_neuron_unit (12 neurons so an out-of-range id exists).
module tb_lif_neuron_unit;

  localparam int SW = 16;
  localparam int VW = 16;
  localparam int NN = 12;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_clear_all;
  logic [VW-1:0] i_threshold;
  logic          i_valid;
  logic          o_ready;
  logic [IW-1:0] i_neuron_id;
  logic [SW-1:0] i_sum;
  logic          o_spike_valid;
  logic          i_spike_ready;
  logic [IW-1:0] o_spike_id;
  logic          o_busy;

  int vectors = 0;
  int errors  = 0;

  lif_neuron_unit #(
    .SUM_WIDTH    (SW),
    .V_WIDTH      (VW),
    .NUM_NEURONS  (NN),
    .ID_WIDTH     (IW),
    .LEAK_SHIFT   (4),
    .REFRAC_STEPS (2),
    .REF_WIDTH    (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clear_all   (i_clear_all),
    .i_threshold   (i_threshold),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_neuron_id   (i_neuron_id),
    .i_sum         (i_sum),
    .o_spike_valid (o_spike_valid),
    .i_spike_ready (i_spike_ready),
    .o_spike_id    (o_spike_id),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one pair, then look at CALC and at the cycle after it.
  task automatic do_update(input logic [IW-1:0] id, input logic [SW-1:0] sum,
                           input logic [VW-1:0] thr, input logic exp_spike, input string tag);
    @(negedge clk);
    i_valid = 1'b1; i_neuron_id = id; i_sum = sum; i_threshold = thr;
    check(32'(o_ready), 32'd1, {tag, "_ready"});
    @(negedge clk);
    i_valid = 1'b0;
    check(32'(o_busy), 32'd1, {tag, "_calc_busy"});
    @(negedge clk);
    check(32'(o_spike_valid), 32'(exp_spike), {tag, "_spike"});
    if (exp_spike) check(32'(o_spike_id), 32'(id), {tag, "_spike_id"});
    else           check(32'(o_ready), 32'd1, {tag, "_back_idle"});
  endtask

  task automatic consume(input string tag);
    i_spike_ready = 1'b1;
    @(negedge clk);
    i_spike_ready = 1'b0;
    check(32'(o_spike_valid), 32'd0, {tag, "_consumed"});
    check(32'(o_ready), 32'd1, {tag, "_ready_after"});
  endtask

  initial begin
    rst_n = 1'b0; i_clear_all = 1'b0; i_threshold = '0; i_valid = 1'b0;
    i_neuron_id = '0; i_sum = '0; i_spike_ready = 1'b0;
    #3;
    check(32'(o_ready), 32'd1, "rst_ready");
    check(32'(o_spike_valid), 32'd0, "rst_spike_valid");
    check(32'(o_spike_id), 32'd0, "rst_spike_id");
    check(32'(o_busy), 32'd0, "rst_busy");
    @(negedge clk); rst_n = 1'b1;

    // v: 0 -> 60; then 60-3+60 = 117 >= 100 fires
    do_update(4'd3, 16'd60, 16'd100, 1'b0, "n3_first");
    do_update(4'd3, 16'd60, 16'd100, 1'b1, "n3_second");
    consume("n3_second");

    // refractory of 2 swallows two updates, the third fires from 0
    do_update(4'd3, 16'd200, 16'd100, 1'b0, "ref1");
    do_update(4'd3, 16'd200, 16'd100, 1'b0, "ref2");
    do_update(4'd3, 16'd200, 16'd100, 1'b1, "ref_done");
    consume("ref_done");

    do_update(4'd2, 16'd0, 16'd0, 1'b1, "thr_zero");
    consume("thr_zero");

    // 0xFFF0 leaks to 0xEFF1, + 0xFFFF saturates to 0xFFFF == threshold
    do_update(4'd4, 16'hFFF0, 16'hFFFF, 1'b0, "sat_load");
    do_update(4'd4, 16'hFFFF, 16'hFFFF, 1'b1, "sat_fire");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check(32'(o_spike_valid), 32'd1, "stall_valid");
      check(32'(o_spike_id), 32'd4, "stall_id");
      check(32'(o_ready), 32'd0, "stall_ready");
    end
    consume("stall");

    do_update(4'd13, 16'd500, 16'd10, 1'b0, "out_of_range");

    do_update(4'd7, 16'd50, 16'd100, 1'b0, "n7_load");
    do_update(4'd5, 16'd20, 16'd10, 1'b1, "n5_fire");
    @(negedge clk);
    i_clear_all = 1'b1; i_valid = 1'b1; i_neuron_id = 4'd5; i_sum = 16'd50; i_threshold = 16'd10;
    #1 check(32'(o_ready), 32'd0, "clear_ready_low");
    @(negedge clk);
    i_clear_all = 1'b0; i_valid = 1'b0;
    check(32'(o_spike_valid), 32'd0, "clear_spike_dropped");
    check(32'(o_busy), 32'd0, "clear_idle_not_accepted");
    check(32'(o_spike_id), 32'd0, "clear_spike_id");
    // n7 cleared: 60 < 100 (would be 47+60=107 otherwise)
    do_update(4'd7, 16'd60, 16'd100, 1'b0, "n7_after_clear");
    do_update(4'd5, 16'd20, 16'd10, 1'b1, "n5_ref_cleared");
    consume("n5_ref_cleared");

    do_update(4'd9, 16'd70, 16'd100, 1'b0, "n9_load");
    @(negedge clk);
    i_valid = 1'b1; i_neuron_id = 4'd9; i_sum = 16'd40; i_threshold = 16'd100;
    @(negedge clk);
    i_valid = 1'b0;
    check(32'(o_busy), 32'd1, "pre_reset_calc");
    rst_n = 1'b0;
    #1;
    check(32'(o_ready), 32'd1, "async_rst_ready");
    check(32'(o_busy), 32'd0, "async_rst_busy");
    check(32'(o_spike_valid), 32'd0, "async_rst_valid");
    check(32'(o_spike_id), 32'd0, "async_rst_id");
    @(negedge clk); rst_n = 1'b1;
    // from 0: 40, then 38+40 = 78, both below 100 (70 kept would give 106)
    do_update(4'd9, 16'd40, 16'd100, 1'b0, "n9_after_rst");
    do_update(4'd9, 16'd40, 16'd100, 1'b0, "n9_after_rst2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
